imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_pkg.sv | 28 ++
 rtl/imem_arbiter_rr_sel.sv | 21 ++
 rtl/imem_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared defines and types for the instruction-memory arbiter slice.
// The `define block is the common defines file; the package wraps it in typed names.
`ifndef IMEM_ARBITER_DEFINES
`define IMEM_ARBITER_DEFINES
`define CPU_WIDTH 32
`define INST_MEM_ADDR_WIDTH 10
`define IMEM_ST_BOOT 2'd0
`define IMEM_ST_RUN 2'd1
`define IMEM_ST_FLUSH 2'd2
`endif

package imem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = `IMEM_ST_BOOT,
        ST_RUN   = `IMEM_ST_RUN,
        ST_FLUSH = `IMEM_ST_FLUSH
    } arb_state_e;

    // Bit positions in the two-entry request/grant vectors.
    localparam int REQ_FETCH = 0;
    localparam int REQ_LD    = 1;

    // Encoding of the last-grant pointer.
    localparam logic LAST_FETCH = 1'b0;
    localparam logic LAST_LD    = 1'b1;

endpackage

// File: rtl/imem_arbiter_rr_sel.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// requester that was not granted last.
module imem_rr_sel
    import imem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o[REQ_FETCH] = (last_i == LAST_LD);
            gnt_o[REQ_LD]    = (last_i == LAST_FETCH);
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates one instruction-memory port between the boot loader and the core
// fetch path. BOOT: loader only, FLUSH: one idle cycle, RUN: round-robin.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int CPU_WIDTH = `CPU_WIDTH,
    parameter int AW        = `INST_MEM_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_req_i,
    input  logic [CPU_WIDTH-1:0] fetch_addr_i,
    output logic                 fetch_gnt_o,
    output logic                 fetch_rvalid_o,
    output logic [CPU_WIDTH-1:0] fetch_rdata_o,
    output logic                 fetch_err_o,
    input  logic                 ld_req_i,
    input  logic [CPU_WIDTH-1:0] ld_addr_i,
    input  logic [CPU_WIDTH-1:0] ld_wdata_i,
    output logic                 ld_gnt_o,
    input  logic                 ld_done_i,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [CPU_WIDTH-1:0] mem_wdata_o,
    input  logic [CPU_WIDTH-1:0] mem_rdata_i,
    output logic                 boot_done_o,
    output logic [1:0]           state_o
);

    // Handshake: a requester holds req/addr/data until its *_gnt_o is seen high
    // in the same cycle; a fetch response (fetch_rvalid_o) follows one cycle later.

    arb_state_e state_q;
    logic       last_q;
    logic       boot_done_q;
    logic       rvalid_q;
    logic       err_q;

    logic [1:0]    rr_req;
    logic [1:0]    rr_gnt;
    logic [AW-1:0] fetch_idx;
    logic [AW-1:0] ld_idx;
    logic          fetch_aligned;
    logic          unused_addr_bits;

    // Upper address bits are dropped so addresses wrap modulo 2^AW words.
    assign fetch_idx     = fetch_addr_i[AW+1:2];
    assign ld_idx        = ld_addr_i[AW+1:2];
    assign fetch_aligned = (fetch_addr_i[1:0] == 2'b00);
    assign unused_addr_bits = ^{fetch_addr_i[CPU_WIDTH-1:AW+2],
                                ld_addr_i[CPU_WIDTH-1:AW+2], ld_addr_i[1:0]};

    assign rr_req = {ld_req_i, fetch_req_i};

    imem_rr_sel u_rr_sel (
        .req_i  (rr_req),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    always_comb begin
        fetch_gnt_o = 1'b0;
        ld_gnt_o    = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = ld_idx;
        mem_wdata_o = ld_wdata_i;
        case (state_q)
            ST_BOOT: begin
                ld_gnt_o = ld_req_i;
                mem_en_o = ld_req_i;
                mem_we_o = ld_req_i;
            end
            ST_RUN: begin
                fetch_gnt_o = rr_gnt[REQ_FETCH];
                ld_gnt_o    = rr_gnt[REQ_LD];
                if (rr_gnt[REQ_FETCH]) begin
                    // A misaligned fetch is granted but never touches memory.
                    mem_en_o   = fetch_aligned;
                    mem_addr_o = fetch_idx;
                end else if (rr_gnt[REQ_LD]) begin
                    mem_en_o = 1'b1;
                    mem_we_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            last_q      <= LAST_LD;
            boot_done_q <= 1'b0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rvalid_q <= fetch_gnt_o;
            err_q    <= fetch_gnt_o && !fetch_aligned;
            if (fetch_gnt_o) begin
                last_q <= LAST_FETCH;
            end else if (ld_gnt_o && (state_q == ST_RUN)) begin
                last_q <= LAST_LD;
            end
            case (state_q)
                ST_BOOT: begin
                    if (ld_done_i) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state_q     <= ST_RUN;
                    boot_done_q <= 1'b1;
                end
                ST_RUN:  state_q <= ST_RUN;
                default: state_q <= ST_BOOT;
            endcase
        end
    end

    // mem_rdata_i is the memory's own output register, valid in the response cycle.
    assign fetch_rdata_o  = (rvalid_q && !err_q) ? mem_rdata_i : '0;
    assign fetch_rvalid_o = rvalid_q;
    assign fetch_err_o    = err_q;
    assign boot_done_o    = boot_done_q;
    assign state_o        = state_q;

endmodule
